// File: rtl/time_keeper_bcd_pkg.sv
// time_pkg: shared constants and helpers for the BCD timekeeper.
//   SEC_MOD/MIN_MOD/HOUR_MOD : field moduli
//   SEC_W/MIN_W/HOUR_W       : binary field widths
//   to_bcd2                  : binary 0..99 -> tens/ones BCD
//   to_12h                   : 24 h hour -> 12 h display hour + pm flag
package time_pkg;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic              pm;
  } disp_hour_t;

  function automatic bcd2_t to_bcd2(input logic [6:0] bin);
    bcd2_t r;
    r.tens = 4'(bin / 7'd10);
    r.ones = 4'(bin % 7'd10);
    return r;
  endfunction

  // Midnight shows as 12 AM, noon as 12 PM.
  function automatic disp_hour_t to_12h(input logic [HOUR_W-1:0] hour);
    disp_hour_t r;
    r.hour = hour;
    r.pm   = 1'b0;
    if (hour == '0) begin
      r.hour = HOUR_W'(12);
    end else if (hour >= HOUR_W'(12)) begin
      r.pm = 1'b1;
      if (hour > HOUR_W'(12)) r.hour = hour - HOUR_W'(12);
    end
    return r;
  endfunction

endpackage

// File: rtl/time_keeper_bcd_wrap_counter.sv
// wrap_counter: modulo-MOD up/down counter used for each time field.
//   clk, rst (sync, active low, loads RST_VAL)
//   clr   : synchronous clear to 0 (priority over en)
//   en    : step enable
//   dn    : 1 = count down, 0 = count up
//   count : current value
//   wrap  : combinational, high when this step wraps the field
module wrap_counter #(
  parameter int W       = 6,
  parameter int MOD     = 60,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         dn,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = en & (dn ? (count == '0) : (count == LAST));

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= W'(RST_VAL);
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (dn) count <= (count == '0) ? LAST : count - W'(1);
      else    count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/time_keeper_bcd.sv
// time_keeper_bcd: prescaled seconds tick driving a 24 h sec/min/hour chain,
// with hour/minute adjust, 12/24 h BCD display, and a day-rollover pulse.
//   clk, rst (sync, active low)
//   adjust, sel_hour, up, down : field adjust controls
//   mode_12h                   : display format select
//   H1,H2,M1,M2,S1,S2,pm       : combinational BCD display
//   sec_tick, day_wrap         : registered one-cycle pulses
// Optional macro ALARM_MATCH_EN adds alarm_hour, alarm_min, alarm_arm inputs
// and the registered alarm_hit pulse.
module time_keeper_bcd
  import time_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adjust,
  input  logic       sel_hour,
  input  logic       up,
  input  logic       down,
  input  logic       mode_12h,
  output logic [1:0] H1,
  output logic [3:0] H2,
  output logic [2:0] M1,
  output logic [3:0] M2,
  output logic [2:0] S1,
  output logic [3:0] S2,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap
`ifdef ALARM_MATCH_EN
  ,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic              alarm_arm,
  output logic              alarm_hit
`endif
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]     prescaler;
  logic              tick;
  logic              tick_run;
  logic              adj_step;
  logic [SEC_W-1:0]  sec;
  logic [MIN_W-1:0]  min;
  logic [HOUR_W-1:0] hour;
  logic              sec_wrap, min_wrap, hour_wrap;
  logic              min_en, hour_en;
  disp_hour_t        h12;
  logic [HOUR_W-1:0] disp_hour;
  bcd2_t             hour_bcd, min_bcd, sec_bcd;

  // With TICK_DIV=1 the prescaler sits at 0 and PS_LAST is 0: tick every cycle.
  assign tick     = (prescaler == PS_LAST);
  assign tick_run = tick & ~adjust;

  always_ff @(posedge clk) begin
    if (!rst)                  prescaler <= '0;
    else if (adjust || tick)   prescaler <= '0;
    else                       prescaler <= prescaler + PW'(1);
  end

  // up and down together cancel; a step exists only when exactly one is high.
  assign adj_step = up ^ down;
  assign min_en   = adjust ? (~sel_hour & adj_step) : sec_wrap;
  // min_wrap can fire while adjusting minutes; it must not carry into hours.
  assign hour_en  = adjust ? (sel_hour & adj_step) : min_wrap;

  wrap_counter #(.W(SEC_W), .MOD(SEC_MOD), .RST_VAL(0)) u_sec (
    .clk(clk), .rst(rst), .clr(adjust), .en(tick_run), .dn(1'b0),
    .count(sec), .wrap(sec_wrap)
  );

  wrap_counter #(.W(MIN_W), .MOD(MIN_MOD), .RST_VAL(RESET_MIN)) u_min (
    .clk(clk), .rst(rst), .clr(1'b0), .en(min_en), .dn(adjust & down),
    .count(min), .wrap(min_wrap)
  );

  wrap_counter #(.W(HOUR_W), .MOD(HOUR_MOD), .RST_VAL(RESET_HOUR)) u_hour (
    .clk(clk), .rst(rst), .clr(1'b0), .en(hour_en), .dn(adjust & down),
    .count(hour), .wrap(hour_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      sec_tick <= tick_run;
      day_wrap <= ~adjust & hour_wrap;
    end
  end

`ifdef ALARM_MATCH_EN
  logic [MIN_W-1:0]  min_next;
  logic [HOUR_W-1:0] hour_next;

  // Compare against the values being loaded so the pulse lines up with sec=0.
  assign min_next  = min_wrap  ? '0 : (sec_wrap ? min + MIN_W'(1)   : min);
  assign hour_next = hour_wrap ? '0 : (min_wrap ? hour + HOUR_W'(1) : hour);

  always_ff @(posedge clk) begin
    if (!rst) alarm_hit <= 1'b0;
    else      alarm_hit <= sec_wrap & ~adjust & alarm_arm &
                           (hour_next == alarm_hour) & (min_next == alarm_min);
  end
`endif

  assign h12       = to_12h(hour);
  assign disp_hour = mode_12h ? h12.hour : hour;
  assign pm        = mode_12h & h12.pm;

  assign hour_bcd = to_bcd2(7'(disp_hour));
  assign min_bcd  = to_bcd2(7'(min));
  assign sec_bcd  = to_bcd2(7'(sec));

  assign H1 = 2'(hour_bcd.tens);
  assign H2 = hour_bcd.ones;
  assign M1 = 3'(min_bcd.tens);
  assign M2 = min_bcd.ones;
  assign S1 = 3'(sec_bcd.tens);
  assign S2 = sec_bcd.ones;

endmodule

// File: tb/tb_time_keeper_bcd.sv
// Bench for time_keeper_bcd: two instances (TICK_DIV=4 from 00:00, and
// TICK_DIV=1 from 23:59) checked every cycle against a seconds-of-day model.
// Compile with ALARM_MATCH_EN to also exercise alarm_hit.
module tb_time_keeper_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_adj, a_sel, a_up, a_dn, a_m12;
  logic b_adj, b_sel, b_up, b_dn, b_m12;
  logic [1:0] a_H1, b_H1;
  logic [3:0] a_H2, b_H2, a_M2, b_M2, a_S2, b_S2;
  logic [2:0] a_M1, b_M1, a_S1, b_S1;
  logic a_pm, b_pm, a_tick, b_tick, a_wrap, b_wrap;
  logic [4:0] a_ah;
  logic [5:0] a_am;
  logic a_arm;
  logic a_hit, b_hit;
  logic exp_hit_a, exp_hit_b;

  int n_checks = 0;
  int n_fail   = 0;

  int tod_a, pc_a, tod_b, pc_b;
  logic tk_a, dw_a, tk_b, dw_b;

  time_keeper_bcd #(.TICK_DIV(4), .RESET_HOUR(0), .RESET_MIN(0)) u4 (
    .clk(clk), .rst(rst), .adjust(a_adj), .sel_hour(a_sel), .up(a_up),
    .down(a_dn), .mode_12h(a_m12), .H1(a_H1), .H2(a_H2), .M1(a_M1),
    .M2(a_M2), .S1(a_S1), .S2(a_S2), .pm(a_pm), .sec_tick(a_tick),
    .day_wrap(a_wrap)
`ifdef ALARM_MATCH_EN
    , .alarm_hour(a_ah), .alarm_min(a_am), .alarm_arm(a_arm), .alarm_hit(a_hit)
`endif
  );

  time_keeper_bcd #(.TICK_DIV(1), .RESET_HOUR(23), .RESET_MIN(59)) u1 (
    .clk(clk), .rst(rst), .adjust(b_adj), .sel_hour(b_sel), .up(b_up),
    .down(b_dn), .mode_12h(b_m12), .H1(b_H1), .H2(b_H2), .M1(b_M1),
    .M2(b_M2), .S1(b_S1), .S2(b_S2), .pm(b_pm), .sec_tick(b_tick),
    .day_wrap(b_wrap)
`ifdef ALARM_MATCH_EN
    , .alarm_hour(5'd0), .alarm_min(6'd0), .alarm_arm(1'b1), .alarm_hit(b_hit)
`endif
  );

`ifndef ALARM_MATCH_EN
  assign a_hit = 1'b0;
  assign b_hit = 1'b0;
`endif

  wire [22:0] obs_a = {a_H1, a_H2, a_M1, a_M2, a_S1, a_S2, a_pm, a_tick, a_wrap};
  wire [22:0] obs_b = {b_H1, b_H2, b_M1, b_M2, b_S1, b_S2, b_pm, b_tick, b_wrap};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] exp_vec(input int tod, input logic m12,
                                          input logic tk, input logic dw);
    int h, m, s, dh;
    logic p;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    dh = h;
    p = 1'b0;
    if (m12) begin
      p  = (h >= 12);
      dh = (h % 12 == 0) ? 12 : h % 12;
    end
    return {2'(dh / 10), 4'(dh % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10), p, tk, dw};
  endfunction

  function automatic logic exp_alarm(input int tod, input logic tk, input logic adj,
                                     input int ah, input int am, input logic arm);
    return rst & ~adj & tk & arm & (tod % 60 == 0) &
           (tod / 3600 == ah) & ((tod / 60) % 60 == am);
  endfunction

  // Time kept as seconds-of-day; adjust edits the h/m split directly.
  task automatic model_step(input int d, input int rh, input int rm,
                            input logic adj, input logic sel, input logic up, input logic dn,
                            inout int tod, inout int pc, output logic tk, output logic dw);
    int h, m;
    tk = 1'b0;
    dw = 1'b0;
    if (!rst) begin
      pc  = 0;
      tod = rh * 3600 + rm * 60;
    end else if (adj) begin
      pc = 0;
      h = tod / 3600;
      m = (tod / 60) % 60;
      if (up != dn) begin
        if (sel) h = (h + (up ? 1 : 23)) % 24;
        else     m = (m + (up ? 1 : 59)) % 60;
      end
      tod = h * 3600 + m * 60;
    end else if (pc == d - 1) begin
      pc  = 0;
      tod = (tod + 1) % 86400;
      tk  = 1'b1;
      dw  = (tod == 0);
    end else begin
      pc++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(4, 0, 0, a_adj, a_sel, a_up, a_dn, tod_a, pc_a, tk_a, dw_a);
    model_step(1, 23, 59, b_adj, b_sel, b_up, b_dn, tod_b, pc_b, tk_b, dw_b);
    exp_hit_a = exp_alarm(tod_a, tk_a, a_adj, int'(a_ah), int'(a_am), a_arm);
    exp_hit_b = exp_alarm(tod_b, tk_b, b_adj, 0, 0, 1'b1);
    #1;
    chk("u4_state", 32'(obs_a), 32'(exp_vec(tod_a, a_m12, tk_a, dw_a)));
    chk("u1_state", 32'(obs_b), 32'(exp_vec(tod_b, b_m12, tk_b, dw_b)));
`ifdef ALARM_MATCH_EN
    chk("u4_alarm_hit", 32'(a_hit), 32'(exp_hit_a));
    chk("u1_alarm_hit", 32'(b_hit), 32'(exp_hit_b));
`endif
  endtask

  initial begin
    logic [22:0] v;
    int n, hits;
    rst = 1'b0;
    {a_adj, a_sel, a_up, a_dn, a_m12} = '0;
    {b_adj, b_sel, b_up, b_dn, b_m12} = '0;
    a_ah = 5'd7; a_am = 6'd30; a_arm = 1'b0;
    tod_a = 0; pc_a = 0; tod_b = 0; pc_b = 0;

    repeat (2) cycle();
    chk("u4_reset_all_zero", 32'(obs_a), 32'd0);
    v = {2'd2, 4'd3, 3'd5, 4'd9, 3'd0, 4'd0, 3'b000};
    chk("u1_reset_2359", 32'(obs_b), 32'(v));

    rst = 1'b1;
    repeat (59) cycle();
    v = {2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9, 3'b010};
    chk("u1_at_235959", 32'(obs_b), 32'(v));
    cycle();
    v = {2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0, 3'b011};
    chk("u1_rollover_000000", 32'(obs_b), 32'(v));
    cycle();
    chk("u1_day_wrap_one_cycle", 32'(b_wrap), 32'd0);

    // minute adjust
    a_adj = 1'b1; a_sel = 1'b0;
    cycle();
    chk("adj_sec_cleared", 32'({a_S1, a_S2}), 32'd0);
    a_dn = 1'b1; cycle(); a_dn = 1'b0;
    chk("adj_min_down_wrap", 32'({a_M1, a_M2}), 32'({3'd5, 4'd9}));
    chk("adj_min_hour_kept", 32'({a_H1, a_H2}), 32'd0);
    a_up = 1'b1; cycle(); a_up = 1'b0;
    chk("adj_min_up_wrap", 32'({a_M1, a_M2}), 32'd0);
    a_up = 1'b1; a_dn = 1'b1; cycle(); a_up = 1'b0; a_dn = 1'b0;
    chk("adj_up_down_cancel", 32'({a_M1, a_M2}), 32'd0);

    // hour adjust
    a_sel = 1'b1;
    a_dn = 1'b1; cycle(); a_dn = 1'b0;
    chk("adj_hour_down_23", 32'({a_H1, a_H2}), 32'({2'd2, 4'd3}));
    a_up = 1'b1; cycle(); a_up = 1'b0;
    chk("adj_hour_up_00", 32'({a_H1, a_H2, a_M1, a_M2, a_S1, a_S2}), 32'd0);

    a_adj = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!a_tick && n < 10);
    chk("first_tick_after_adjust", 32'(n), 32'd4);

    // 12 h display
    a_adj = 1'b1; a_sel = 1'b1; a_m12 = 1'b1;
    cycle();
    chk("h12_hour0", 32'({a_H1, a_H2, a_pm}), 32'({2'd1, 4'd2, 1'b0}));
    a_up = 1'b1; repeat (11) cycle(); a_up = 1'b0;
    chk("h12_hour11", 32'({a_H1, a_H2, a_pm}), 32'({2'd1, 4'd1, 1'b0}));
    a_up = 1'b1; cycle(); a_up = 1'b0;
    chk("h12_hour12", 32'({a_H1, a_H2, a_pm}), 32'({2'd1, 4'd2, 1'b1}));
    a_up = 1'b1; cycle(); a_up = 1'b0;
    chk("h12_hour13", 32'({a_H1, a_H2, a_pm}), 32'({2'd0, 4'd1, 1'b1}));
    a_m12 = 1'b0; cycle();
    chk("h24_hour13", 32'({a_H1, a_H2, a_pm}), 32'({2'd1, 4'd3, 1'b0}));
    a_m12 = 1'b1; cycle();
    chk("h12_toggle_kept", 32'({a_H1, a_H2, a_pm}), 32'({2'd0, 4'd1, 1'b1}));

`ifdef ALARM_MATCH_EN
    // set 07:29 then run into 07:30:00
    a_dn = 1'b1; repeat (6) cycle();
    a_sel = 1'b0; repeat (31) cycle(); a_dn = 1'b0;
    chk("alarm_setup_0729", 32'({a_H1, a_H2, a_M1, a_M2}), 32'({2'd0, 4'd7, 3'd2, 4'd9}));
    a_arm = 1'b1; a_adj = 1'b0; a_m12 = 1'b0;
    hits = 0;
    repeat (260) begin cycle(); hits += int'(a_hit); end
    chk("alarm_armed_hits", 32'(hits), 32'd1);
    a_adj = 1'b1; a_dn = 1'b1; cycle(); a_dn = 1'b0;
    a_arm = 1'b0; a_adj = 1'b0;
    hits = 0;
    repeat (260) begin cycle(); hits += int'(a_hit); end
    chk("alarm_disarmed_hits", 32'(hits), 32'd0);
    a_arm = 1'b1;
`endif

    // randomized phase
    a_adj = 1'b0; a_sel = 1'b0; a_up = 1'b0; a_dn = 1'b0;
    repeat (500) begin
      rst   = ($urandom_range(99) != 0);
      if ($urandom_range(15) == 0) a_adj = ~a_adj;
      if ($urandom_range(15) == 0) b_adj = ~b_adj;
      a_sel = 1'($urandom); a_up = 1'($urandom); a_dn = 1'($urandom);
      b_sel = 1'($urandom); b_up = 1'($urandom); b_dn = 1'($urandom);
      a_m12 = 1'($urandom); b_m12 = 1'($urandom);
      a_ah  = 5'($urandom_range(23)); a_am = 6'($urandom_range(59));
      cycle();
    end

    // mid-count reset
    rst = 1'b1;
    {a_adj, a_sel, a_up, a_dn, a_m12} = '0;
    {b_adj, b_sel, b_up, b_dn, b_m12} = '0;
    repeat (10) cycle();
    rst = 1'b0; cycle();
    chk("u4_midcount_reset", 32'(obs_a), 32'd0);
    v = {2'd2, 4'd3, 3'd5, 4'd9, 3'd0, 4'd0, 3'b000};
    chk("u1_midcount_reset", 32'(obs_b), 32'(v));
    rst = 1'b1; cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
